// File: rtl/smc_pipe_control.sv
// Pipelined sliding-mode SEA torque controller.
// Six register stages from sample capture to u; the last u is fed back
// (scaled by 1/Jn) into stage 1 of later samples. Optional boundary-layer
// switching law and saturating output clamp with a sat flag.
module smc_pipe_control #(
  parameter int W         = 32,
  parameter int OW        = 16,
  parameter int REF_FRAC  = 16,
  parameter int LAMBDA    = 25,
  parameter int K         = 10,
  parameter int BA        = 400,
  parameter int JA        = 17,
  parameter int BE        = 20,
  parameter int DM        = 10000,
  parameter int JN_SHIFT  = 4,
  parameter int OUT_SHIFT = 6,
  parameter int PHI_SHIFT = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic          mode,
  input  logic [W-1:0]  thetan,
  input  logic [W-1:0]  dthetan,
  input  logic [W-1:0]  theta,
  input  logic [W-1:0]  dtheta,
  output logic          out_valid,
  output logic [OW-1:0] u,
  output logic          sat
);

  localparam logic signed [W-1:0] LAMBDA_C = W'(LAMBDA);
  localparam logic signed [W-1:0] K_C      = W'(K);
  localparam logic signed [W-1:0] BA_C     = W'(BA);
  localparam logic signed [W-1:0] JA_C     = W'(JA);
  localparam logic signed [W-1:0] BE_C     = W'(BE);
  localparam logic signed [W-1:0] DM_C     = W'(DM);
  // Output range limits expressed at the W+1 width of the final sum.
  localparam logic signed [W:0]   OMAX_C   = (W+1)'(2**(OW-1) - 1);
  localparam logic signed [W:0]   OMIN_C   = ~OMAX_C;

  // Wrapping absolute value: the most negative value maps to itself.
  function automatic logic signed [W-1:0] abs_w(input logic signed [W-1:0] x);
    abs_w = x[W-1] ? -x : x;
  endfunction

  // Stage 1 registers
  logic                v1_r, mode1_r;
  logic signed [W-1:0] e_r, de1_r, ldth_r, jnu_r, adth_r, bdth1_r;
  // Stage 2 registers
  logic                v2_r, mode2_r;
  logic signed [W-1:0] le_r, temp_r, atemp_r, h1_r, de2_r, bdth2_r;
  // Stage 3 registers
  logic                v3_r, mode3_r;
  logic signed [W-1:0] s_r, h2_r, h3_r, jtemp3_r, bdth3_r;
  // Stage 4 registers
  logic                v4_r;
  logic signed [W-1:0] ks_r, sw_r, jtemp4_r, bdth4_r;
  // Stage 5 registers
  logic                v5_r;
  logic signed [W-1:0] u1_r, u2_r;
  // Stage 6 / output registers
  logic                ov_r, sat_r;
  logic [OW-1:0]       u_r;
  logic signed [W-1:0] u_prev_r;

  // Stage 4 and stage 6 combinational terms
  logic signed [W-1:0]   h_s, sw_s;
  logic signed [2*W-1:0] h_wide_s, s_wide_s, prod_s, phi_s;
  logic signed [W:0]     ut_s, uo_s;
  logic [OW-1:0]         uc_s;
  logic                  sat_s;

  // Stage 1: capture errors, measured-velocity terms and scaled feedback
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_r <= 1'b0; mode1_r <= 1'b0;
      e_r <= '0; de1_r <= '0; ldth_r <= '0; jnu_r <= '0; adth_r <= '0; bdth1_r <= '0;
    end else begin
      v1_r <= in_valid;
      if (in_valid) begin
        mode1_r <= mode;
        e_r     <= $signed(theta) - ($signed(thetan) >>> REF_FRAC);
        de1_r   <= $signed(dtheta) - ($signed(dthetan) >>> REF_FRAC);
        ldth_r  <= LAMBDA_C * $signed(dtheta);
        jnu_r   <= u_prev_r >>> JN_SHIFT;
        adth_r  <= abs_w($signed(dtheta));
        bdth1_r <= BA_C * $signed(dtheta);
      end
    end
  end

  // Stage 2: surface error term, inertia residual and damping bound
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2_r <= 1'b0; mode2_r <= 1'b0;
      le_r <= '0; temp_r <= '0; atemp_r <= '0; h1_r <= '0; de2_r <= '0; bdth2_r <= '0;
    end else begin
      v2_r <= v1_r;
      if (v1_r) begin
        mode2_r <= mode1_r;
        le_r    <= LAMBDA_C * e_r;
        temp_r  <= jnu_r - ldth_r;
        atemp_r <= abs_w(jnu_r - ldth_r);
        h1_r    <= BE_C * adth_r;
        de2_r   <= de1_r;
        bdth2_r <= bdth1_r;
      end
    end
  end

  // Stage 3: sliding surface s and the partial switching-gain terms
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v3_r <= 1'b0; mode3_r <= 1'b0;
      s_r <= '0; h2_r <= '0; h3_r <= '0; jtemp3_r <= '0; bdth3_r <= '0;
    end else begin
      v3_r <= v2_r;
      if (v2_r) begin
        mode3_r  <= mode2_r;
        s_r      <= de2_r + le_r;
        h2_r     <= h1_r + DM_C;
        h3_r     <= atemp_r >>> 1;
        jtemp3_r <= JA_C * temp_r;
        bdth3_r  <= bdth2_r;
      end
    end
  end

  // Stage 4 switching law: sign(s)*h, or h*s/phi clamped to [-h, +h]
  always_comb begin
    h_s      = h2_r + h3_r;
    h_wide_s = {{W{h_s[W-1]}}, h_s};
    s_wide_s = {{W{s_r[W-1]}}, s_r};
    prod_s   = h_wide_s * s_wide_s;
    phi_s    = prod_s >>> PHI_SHIFT;
    sw_s     = h_s;
    case (mode3_r)
      1'b0: begin
        if (s_r[W-1]) begin
          sw_s = -h_s;
        end else begin
          sw_s = h_s;
        end
      end
      1'b1: begin
        if (phi_s > h_wide_s) begin
          sw_s = h_s;
        end else if (phi_s < -h_wide_s) begin
          sw_s = -h_s;
        end else begin
          sw_s = phi_s[W-1:0];
        end
      end
      default: sw_s = h_s;
    endcase
  end

  // Stage 4: reaching term and switching term
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v4_r <= 1'b0;
      ks_r <= '0; sw_r <= '0; jtemp4_r <= '0; bdth4_r <= '0;
    end else begin
      v4_r <= v3_r;
      if (v3_r) begin
        ks_r     <= K_C * s_r;
        sw_r     <= sw_s;
        jtemp4_r <= jtemp3_r;
        bdth4_r  <= bdth3_r;
      end
    end
  end

  // Stage 5: the two partial torque sums
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v5_r <= 1'b0;
      u1_r <= '0; u2_r <= '0;
    end else begin
      v5_r <= v4_r;
      if (v4_r) begin
        u1_r <= bdth4_r - ks_r;
        u2_r <= jtemp4_r + sw_r;
      end
    end
  end

  // Stage 6 final sum at W+1 bits, floor shift and output clamp
  always_comb begin
    ut_s = {u1_r[W-1], u1_r} + {u2_r[W-1], u2_r};
    uo_s = ut_s >>> OUT_SHIFT;
    if (uo_s > OMAX_C) begin
      uc_s  = {1'b0, {(OW-1){1'b1}}};
      sat_s = 1'b1;
    end else if (uo_s < OMIN_C) begin
      uc_s  = {1'b1, {(OW-1){1'b0}}};
      sat_s = 1'b1;
    end else begin
      uc_s  = uo_s[OW-1:0];
      sat_s = 1'b0;
    end
  end

  // Stage 6: register the command, saturation flag and feedback value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ov_r     <= 1'b0;
      u_r      <= '0;
      sat_r    <= 1'b0;
      u_prev_r <= '0;
    end else begin
      ov_r <= v5_r;
      if (v5_r) begin
        u_r      <= uc_s;
        sat_r    <= sat_s;
        u_prev_r <= {{(W-OW){uc_s[OW-1]}}, uc_s};
      end
    end
  end

  assign out_valid = ov_r;
  assign u         = u_r;
  assign sat       = sat_r;

endmodule

// File: doc/smc_pipe_control.md
Name: smc_pipe_control

Overview:
- Clocked, fully pipelined, parametrised successor to the combinational 3-1 sliding-mode SEA motor controller.
- Computes the SMC torque command u from reference (thetan, dthetan) and measured (theta, dtheta) with a valid handshake and a fixed 6-cycle latency.
- Adds a selectable boundary-layer (saturated) switching law, output clamping with a saturation flag, and an internal u feedback register.
- Sits between the trajectory generator and the PWM/current-command stage.

Parameters:
- W, 32: data/intermediate width; two's complement, wraps mod 2^W.
- OW, 16: output width.
- REF_FRAC, 16: arithmetic right shift applied to thetan/dthetan.
- LAMBDA, 25: sliding-surface gain (Bn/Jn).
- K, 10: reaching gain.
- BA, 400: nominal damping.
- JA, 17: average inertia.
- BE, 20: damping uncertainty bound.
- DM, 10000: disturbance bound.
- JN_SHIFT, 4: u_prev scaling shift (1/Jn).
- OUT_SHIFT, 6: final output shift.
- PHI_SHIFT, 8: boundary-layer width exponent, phi = 2^PHI_SHIFT.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  sample strobe; one sample accepted per cycle, no backpressure.
- mode  in  1  0 = sign switching, 1 = boundary-layer switching; sampled with in_valid.
- thetan  in  W  reference position, REF_FRAC fractional bits.
- dthetan  in  W  reference velocity, REF_FRAC fractional bits.
- theta  in  W  measured position, integer.
- dtheta  in  W  measured velocity, integer.
- out_valid  out  1  u valid, exactly 6 cycles after in_valid.
- u  out  OW  clamped torque command.
- sat  out  1  high with out_valid when u was clamped.

Behaviour:
- Reset (async, active-high): all pipeline valid bits, u, sat and u_prev are cleared to 0 immediately. In-flight samples are discarded; no out_valid is produced for them after reset is released.
- Stage 1 (registered on in_valid):
  - e = theta - (thetan>>>REF_FRAC)
  - de = dtheta - (dthetan>>>REF_FRAC)
  - ldth = LAMBDA*dtheta
  - jnu = u_prev>>>JN_SHIFT
  - adth = |dtheta|
  - bdth = BA*dtheta
  - mode is captured here.
- Stage 2:
  - le = LAMBDA*e
  - temp = jnu - ldth
  - atemp = |temp|
  - h1 = BE*adth
- Stage 3:
  - s = de + le
  - h2 = h1 + DM
  - h3 = atemp>>>1
  - jtemp = JA*temp
- Stage 4:
  - ks = K*s
  - h = h2 + h3
  - Switching term sw:
    - mode 0: sw = +h if s >= 0, else -h.
    - mode 1: sw = (h*s)>>>PHI_SHIFT, computed at 2W and then clamped to [-h, +h]. When |s| >= 2^PHI_SHIFT, sw = sign(s)*h, identical to mode 0.
- Stage 5:
  - u1 = bdth - ks
  - u2 = jtemp + sw
- Stage 6:
  - ut = u1 + u2, computed at W+1 bits.
  - uo = ut>>>OUT_SHIFT (arithmetic, floor).
  - uo is clamped to [-2^(OW-1), 2^(OW-1)-1]; sat = 1 when clamping occurs.
  - u, sat and out_valid are registered here.
- Arithmetic rules:
  - Products are formed at full width and truncated to the low W bits.
  - Adders wrap mod 2^W, except the final ut.
  - |x| of the most negative value equals itself (wrap).
- Feedback: u_prev <= sign-extended u in the same cycle out_valid rises; otherwise it holds.
  - Stage 1 uses the u_prev value current at capture time.
  - Back-to-back samples therefore see the output of the sample 6 earlier or older; this is intended.
- Registered values are held between samples; u and sat hold their last value while out_valid = 0.
- in_valid on consecutive cycles produces out_valid on consecutive cycles, in order.

Test Plan:
1. Assert rst mid-stream with 3 samples in flight -> u = 0, sat = 0, out_valid = 0 immediately; no out_valid from the flushed samples after release.
2. After reset, mode 0, all inputs 0 -> s = 0, u2 = 10000, ut = 10000; out_valid 6 cycles later, u = 156, sat = 0.
3. After reset, mode 0, theta = 1, others 0 -> s = 25, u1 = -250, u2 = 10000; u = 152. Repeat with theta = -1 -> u = -153.
4. After reset, mode 1, theta = 1, others 0 -> sw = 976, ut = 726, u = 11. Repeat with theta = 20 (s = 500 >= 256) -> result equals mode 0.
5. After reset, mode 0, dtheta = 2000000, others 0 -> ut = -4990000, unclamped uo = -77969; u = -32768, sat = 1.
6. Apply 8 consecutive in_valid cycles -> 8 consecutive out_valid cycles in order, first at +6. u_prev of sample 7 equals u of sample 1.
